nsu_packet_proc: RTL



---
 rtl/nsu_packet_proc.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/nsu_packet_proc.sv
`default_nettype none
// ============================================================================
// Module   : nsu_packet_proc
// Purpose  : NSU response packetizer. Accepts response commands and DDR read
//            data from the noc_clk side of the crossing FIFOs and emits NoC
//            packets (head flit, data flits, tail flit) toward the requesting
//            NMU. Read data is split into up to VIRTUAL_CH_NUM packets of at
//            most PKT_DATA_FLITS data flits; other response types produce a
//            single head+tail packet.
// Ports    : noc_clk / noc_rst_n      clock, asynchronous active-low reset
//            rsp_valid/ready/type/dest_id/len   response command handshake
//            rdata_in/empty/rd_en     first-word-fall-through read-data FIFO
//            flit_out/valid/last/ready          flit stream to router
//            nsu_tx_busy              response in progress
//            rsp_done                 pulse alongside the final tail flit
// Revision : 1.0  initial release
// ============================================================================
module nsu_packet_proc #(
  parameter int                DATA_WIDTH     = 128,
  parameter int                ID_WIDTH       = 4,
  parameter int                VIRTUAL_CH_NUM = 8,
  parameter int                PKT_DATA_FLITS = 32,
  parameter logic [ID_WIDTH-1:0] NODE_ID      = '0,
  parameter logic [2:0]        TYPE_RD_DATA   = 3'b001,
  parameter logic [2:0]        TYPE_WR_RSP    = 3'b011,
  parameter logic [15:0]       HEAD_CODE_H    = 16'hAA55,
  parameter logic [15:0]       HEAD_CODE_E    = 16'h55AA,
  parameter logic [15:0]       TAIL_CODE_H    = 16'h5A5A,
  parameter logic [15:0]       TAIL_CODE_E    = 16'hA5A5
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [2:0]            rsp_type,
  input  logic [ID_WIDTH-1:0]   rsp_dest_id,
  input  logic [7:0]            rsp_len,
  input  logic [DATA_WIDTH-1:0] rdata_in,
  input  logic                  rdata_empty,
  output logic                  rdata_rd_en,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  output logic                  flit_last,
  input  logic                  flit_ready,
  output logic                  nsu_tx_busy,
  output logic                  rsp_done
);

  localparam int PKT_SHIFT = $clog2(PKT_DATA_FLITS);
  localparam int CNT_W     = PKT_SHIFT + 1;
  localparam int CODE_E_W  = DATA_WIDTH - 16 - 2*ID_WIDTH - 3 - VIRTUAL_CH_NUM - 40;

  localparam logic [8:0]                BEATS_PER_PKT = 9'(PKT_DATA_FLITS);
  localparam logic [CNT_W-1:0]          CNT_FULL      = CNT_W'(PKT_DATA_FLITS);
  localparam logic [CNT_W-1:0]          CNT_ONE       = CNT_W'(1);
  localparam logic [VIRTUAL_CH_NUM-1:0] ONE_HOT0      = VIRTUAL_CH_NUM'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [2:0]                cur_type;
  logic [ID_WIDTH-1:0]       cur_dest;
  logic [8:0]                beat_left;
  logic [CNT_W-1:0]          pkt_cnt;
  logic [VIRTUAL_CH_NUM-1:0] pkt_idx;
  logic [VIRTUAL_CH_NUM-1:0] pkt_num;
  logic                      ready_en;

  logic                      adv;
  logic                      cmd_hs;
  logic                      rd_pkt;
  logic                      more_pkts;
  logic [DATA_WIDTH-1:0]     head_flit;
  logic [DATA_WIDTH-1:0]     tail_flit;

  // A type configured as the write-response code never gets a data phase,
  // even if both codes were ever parameterised to the same value.
  function automatic logic carries_data(input logic [2:0] t);
    return (t == TYPE_RD_DATA) && (t != TYPE_WR_RSP);
  endfunction

  // The output slot can take a new flit when it is empty or being drained.
  assign adv       = ~flit_valid | flit_ready;
  assign cmd_hs    = rsp_valid & rsp_ready;
  assign rd_pkt    = carries_data(cur_type);
  assign more_pkts = rd_pkt && (beat_left != 9'd0);

  assign head_flit = {HEAD_CODE_H, NODE_ID, cur_dest, cur_type, pkt_idx, 40'b0,
                      {(CODE_E_W-16){1'b0}}, HEAD_CODE_E};
  assign tail_flit = {TAIL_CODE_H, NODE_ID, cur_dest, cur_type, pkt_num, 40'b0,
                      {(CODE_E_W-16){1'b0}}, TAIL_CODE_E};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_hs) state_nxt = S_HEAD;
      S_HEAD: if (adv)    state_nxt = rd_pkt ? S_DATA : S_TAIL;
      S_DATA: if (adv && !rdata_empty && (pkt_cnt == CNT_ONE)) state_nxt = S_TAIL;
      S_TAIL: if (adv)    state_nxt = more_pkts ? S_HEAD : S_IDLE;
      default:            state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // ready_en keeps rsp_ready low while reset is held, when state already
    // reads IDLE.
    rsp_ready   = (state == S_IDLE) && ready_en;
    nsu_tx_busy = (state != S_IDLE);
    rdata_rd_en = (state == S_DATA) && adv && !rdata_empty;
  end

  // --------------------------------------------------------------------------
  // Command capture, counters and output flit register
  // --------------------------------------------------------------------------
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      ready_en   <= 1'b0;
      rsp_done   <= 1'b0;
      cur_type   <= '0;
      cur_dest   <= '0;
      beat_left  <= '0;
      pkt_cnt    <= '0;
      pkt_idx    <= '0;
      pkt_num    <= '0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      flit_last  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      rsp_done <= 1'b0;

      if (cmd_hs) begin
        cur_type  <= rsp_type;
        cur_dest  <= rsp_dest_id;
        beat_left <= {1'b0, rsp_len} + 9'd1;
        pkt_idx   <= ONE_HOT0;
        // Packet count is floor(len / PKT_DATA_FLITS) + 1, so the one-hot
        // pack_num bit index is simply len shifted down.
        pkt_num   <= carries_data(rsp_type) ? (ONE_HOT0 << (rsp_len >> PKT_SHIFT))
                                            : ONE_HOT0;
      end

      if (adv) begin
        case (state)
          S_HEAD: begin
            flit_out   <= head_flit;
            flit_valid <= 1'b1;
            flit_last  <= 1'b0;
            pkt_cnt    <= (beat_left >= BEATS_PER_PKT) ? CNT_FULL
                                                       : beat_left[CNT_W-1:0];
          end
          S_DATA: begin
            if (!rdata_empty) begin
              flit_out   <= rdata_in;
              flit_valid <= 1'b1;
              flit_last  <= 1'b0;
              beat_left  <= beat_left - 9'd1;
              pkt_cnt    <= pkt_cnt - CNT_ONE;
            end else begin
              // FIFO underrun: emit a bubble rather than stall the router.
              flit_valid <= 1'b0;
            end
          end
          S_TAIL: begin
            flit_out   <= tail_flit;
            flit_valid <= 1'b1;
            flit_last  <= 1'b1;
            if (more_pkts) pkt_idx  <= pkt_idx << 1;
            else           rsp_done <= 1'b1;
          end
          default: begin
            // Idle: retire the last tail once the router has taken it.
            flit_valid <= 1'b0;
            flit_last  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
